change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser.sv | 201 ++++++++++++++++++++
 tb/tb_change_dispenser.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser
//
// Pays out owed change as nickels and dimes, one coin at a time. Each coin is
// ejected with a one-cycle solenoid pulse. The hopper sensor then confirms the
// drop with CoinAck, and only that confirmation reduces the amount owed.
// Dimes are preferred whenever at least 10c is owed and a dime is in stock.
// A stock shortage or a missing drop confirmation parks the machine in FAULT
// until ClearFault. The amount owed is kept across a fault, so payout resumes.
//
// Handshake: Return* and CoinAck are single-cycle pulses sampled on the rising
// clock edge. There is no back-pressure. Every request pulse is accepted in
// every state, and a CoinAck only counts while a coin is awaiting confirmation.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   ReturnNickel      +1 nickel unit owed (5c)
//   ReturnDime        +2 nickel units owed (10c)
//   ReturnTwoDimes    +4 nickel units owed (20c)
//   CoinAck           drop confirmation for the coin in flight
//   LoadNickel/Dime   add one coin to the inventory per high cycle
//   ClearFault        leave FAULT
//   EjectNickel/Dime  one-cycle eject pulses
//   Busy, Fault       status flags
//   FaultCode         00 none, 01 shortage, 10 jam (no drop confirmation)
//   Owed              change still owed, in nickel units
//   NickelCount       nickel inventory
//   DimeCount         dime inventory
//   state_dbg         current FSM state encoding, for observation only
module change_dispenser #(
   parameter int NICKEL_INIT = 20,
   parameter int DIME_INIT   = 20,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ReturnNickel,
   input  logic       ReturnDime,
   input  logic       ReturnTwoDimes,
   input  logic       CoinAck,
   input  logic       LoadNickel,
   input  logic       LoadDime,
   input  logic       ClearFault,
   output logic       EjectNickel,
   output logic       EjectDime,
   output logic       Busy,
   output logic       Fault,
   output logic [1:0] FaultCode,
   output logic [4:0] Owed,
   output logic [7:0] NickelCount,
   output logic [7:0] DimeCount,
   output logic [2:0] state_dbg
);

   localparam int TW = ($clog2(ACK_TIMEOUT + 1) < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST   = TW'(ACK_TIMEOUT);
   localparam logic [7:0]    NICKEL_RST = 8'(NICKEL_INIT);
   localparam logic [7:0]    DIME_RST   = 8'(DIME_INIT);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SELECT   = 3'd1,
      ST_EJECT_N  = 3'd2,
      ST_EJECT_D  = 3'd3,
      ST_WAIT_ACK = 3'd4,
      ST_FAULT    = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic [4:0]    owed_q, owed_d;
   logic [7:0]    nickel_q, nickel_d;
   logic [7:0]    dime_q, dime_d;
   logic          coin_dime_q, coin_dime_d;   // coin in flight: 1 = dime, 0 = nickel
   logic [TW-1:0] tmo_q, tmo_d;
   logic [1:0]    fcode_q, fcode_d;

   logic          eject_n, eject_d;
   logic [6:0]    paid, owed_sum, owed_diff;
   logic [TW-1:0] tmo_inc;

   always_comb begin
      state_d     = state_q;
      coin_dime_d = coin_dime_q;
      tmo_d       = tmo_q;
      fcode_d     = fcode_q;
      eject_n     = 1'b0;
      eject_d     = 1'b0;
      paid        = 7'd0;
      tmo_inc     = tmo_q + TW'(1);

      // Only a confirmed drop reduces the amount owed.
      if (state_q == ST_WAIT_ACK && CoinAck) begin
         paid = coin_dime_q ? 7'd2 : 7'd1;
      end

      // All simultaneous requests are summed, then the result is clamped to 0..31.
      owed_sum  = {2'b00, owed_q} + {6'd0, ReturnNickel} + {5'd0, ReturnDime, 1'b0}
                + {4'd0, ReturnTwoDimes, 2'b00};
      owed_diff = owed_sum - paid;
      if (owed_sum < paid) begin
         owed_d = 5'd0;
      end else if (owed_diff > 7'd31) begin
         owed_d = 5'd31;
      end else begin
         owed_d = owed_diff[4:0];
      end

      case (state_q)
         ST_IDLE: begin
            if (owed_q != 5'd0) state_d = ST_SELECT;
         end
         ST_SELECT: begin
            if (owed_q >= 5'd2 && dime_q != 8'd0) begin
               state_d = ST_EJECT_D;
            end else if (nickel_q != 8'd0) begin
               state_d = ST_EJECT_N;
            end else begin
               state_d = ST_FAULT;
               fcode_d = 2'b01;
            end
         end
         ST_EJECT_D: begin
            eject_d     = 1'b1;
            coin_dime_d = 1'b1;
            tmo_d       = '0;
            state_d     = ST_WAIT_ACK;
         end
         ST_EJECT_N: begin
            eject_n     = 1'b1;
            coin_dime_d = 1'b0;
            tmo_d       = '0;
            state_d     = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (CoinAck) begin
               tmo_d   = '0;
               state_d = (owed_d != 5'd0) ? ST_SELECT : ST_IDLE;
            end else if (tmo_inc == TMO_LAST) begin
               // The coin never confirmed; treat it as jammed and keep the debt.
               tmo_d   = '0;
               fcode_d = 2'b10;
               state_d = ST_FAULT;
            end else begin
               tmo_d = tmo_inc;
            end
         end
         ST_FAULT: begin
            if (ClearFault) begin
               fcode_d = 2'b00;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A load and an eject of the same coin in one cycle cancel out.
      nickel_d = nickel_q;
      if (LoadNickel && !eject_n) begin
         nickel_d = (nickel_q == 8'hFF) ? 8'hFF : nickel_q + 8'd1;
      end else if (!LoadNickel && eject_n) begin
         nickel_d = nickel_q - 8'd1;
      end

      dime_d = dime_q;
      if (LoadDime && !eject_d) begin
         dime_d = (dime_q == 8'hFF) ? 8'hFF : dime_q + 8'd1;
      end else if (!LoadDime && eject_d) begin
         dime_d = dime_q - 8'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         owed_q      <= 5'd0;
         nickel_q    <= NICKEL_RST;
         dime_q      <= DIME_RST;
         coin_dime_q <= 1'b0;
         tmo_q       <= '0;
         fcode_q     <= 2'b00;
      end else begin
         state_q     <= state_d;
         owed_q      <= owed_d;
         nickel_q    <= nickel_d;
         dime_q      <= dime_d;
         coin_dime_q <= coin_dime_d;
         tmo_q       <= tmo_d;
         fcode_q     <= fcode_d;
      end
   end

   assign EjectNickel = eject_n;
   assign EjectDime   = eject_d;
   assign Busy        = (state_q != ST_IDLE);
   assign Fault       = (state_q == ST_FAULT);
   assign FaultCode   = fcode_q;
   assign Owed        = owed_q;
   assign NickelCount = nickel_q;
   assign DimeCount   = dime_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Testbench for change_dispenser. It drives three instances from shared
// stimulus: instance 0 uses the defaults, instance 1 has no dimes loaded, and
// instance 2 starts with no nickels and a single dime.
module tb_change_dispenser;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic rn = 1'b0, rd = 1'b0, r2 = 1'b0, ack = 1'b0;
   logic ln = 1'b0, ld = 1'b0, clr = 1'b0;

   logic [2:0]      ej_n, ej_d, busy, fault;
   logic [2:0][1:0] fcode;
   logic [2:0][4:0] owed;
   logic [2:0][7:0] ncnt, dcnt;
   logic [2:0][2:0] st;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   change_dispenser u_def (
      .clk(clk), .reset(reset), .ReturnNickel(rn), .ReturnDime(rd), .ReturnTwoDimes(r2),
      .CoinAck(ack), .LoadNickel(ln), .LoadDime(ld), .ClearFault(clr),
      .EjectNickel(ej_n[0]), .EjectDime(ej_d[0]), .Busy(busy[0]), .Fault(fault[0]),
      .FaultCode(fcode[0]), .Owed(owed[0]), .NickelCount(ncnt[0]), .DimeCount(dcnt[0]),
      .state_dbg(st[0]));

   change_dispenser #(.DIME_INIT(0)) u_nodime (
      .clk(clk), .reset(reset), .ReturnNickel(rn), .ReturnDime(rd), .ReturnTwoDimes(r2),
      .CoinAck(ack), .LoadNickel(ln), .LoadDime(ld), .ClearFault(clr),
      .EjectNickel(ej_n[1]), .EjectDime(ej_d[1]), .Busy(busy[1]), .Fault(fault[1]),
      .FaultCode(fcode[1]), .Owed(owed[1]), .NickelCount(ncnt[1]), .DimeCount(dcnt[1]),
      .state_dbg(st[1]));

   change_dispenser #(.NICKEL_INIT(0), .DIME_INIT(1)) u_short (
      .clk(clk), .reset(reset), .ReturnNickel(rn), .ReturnDime(rd), .ReturnTwoDimes(r2),
      .CoinAck(ack), .LoadNickel(ln), .LoadDime(ld), .ClearFault(clr),
      .EjectNickel(ej_n[2]), .EjectDime(ej_d[2]), .Busy(busy[2]), .Fault(fault[2]),
      .FaultCode(fcode[2]), .Owed(owed[2]), .NickelCount(ncnt[2]), .DimeCount(dcnt[2]),
      .state_dbg(st[2]));

   // Watchdog against a hung run.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got=running exp=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0d exp=%0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      rn = 1'b0; rd = 1'b0; r2 = 1'b0; ack = 1'b0;
      ln = 1'b0; ld = 1'b0; clr = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // One-cycle request pulse; returns at the negedge where it is removed.
   task automatic pulse(input logic p_rn, input logic p_rd, input logic p_r2, input logic p_clr);
      @(negedge clk);
      rn = p_rn; rd = p_rd; r2 = p_r2; clr = p_clr;
      @(negedge clk);
      rn = 1'b0; rd = 1'b0; r2 = 1'b0; clr = 1'b0;
   endtask

   // Confirms each ejected coin three cycles after its eject pulse, until the
   // instance is idle with nothing owed or it faults. seq collects the coins
   // in order (1 = dime).
   task automatic payout(input int inst, input bit inject_dime, output int n_nick,
                         output int n_dime, output logic [7:0] seq, output int peak);
      int  pend, dly, cyc;
      bit  injected, done;
      n_nick = 0; n_dime = 0; seq = 8'd0; peak = 0;
      pend = 0; dly = 0; injected = 1'b0; done = 1'b0;
      for (cyc = 0; cyc < 300 && !done; cyc++) begin
         @(negedge clk);
         rd = 1'b0; ack = 1'b0;
         if (int'(owed[inst]) > peak) peak = int'(owed[inst]);
         if (ej_n[inst]) begin
            n_nick++; seq = {seq[6:0], 1'b0}; pend = 1; dly = 3;
         end else if (ej_d[inst]) begin
            n_dime++; seq = {seq[6:0], 1'b1}; pend = 1; dly = 3;
         end else if (pend != 0) begin
            if (inject_dime && !injected) begin
               rd = 1'b1; injected = 1'b1;
            end
            dly--;
            if (dly == 0) begin
               ack = 1'b1; pend = 0;
            end
         end
         if (fault[inst]) done = 1'b1;
         if (pend == 0 && !busy[inst] && owed[inst] == 5'd0 && !ack) done = 1'b1;
      end
      chk("payout_finished", {31'd0, done}, 32'd1);
      clear_inputs();
   endtask

   // Randomised run on the default instance against a reference model built from
   // the payout rules: owed = requests - confirmed coins, inventory = loads - ejects,
   // and dimes are chosen whenever at least two units are owed and a dime is in stock.
   task automatic random_run();
      int m_owed, m_n, m_d, pend, dly, paid, tmp;
      int prev_owed, prev_d;
      bit prev_ej, e_n, e_d, quiet;
      m_owed = 0; m_n = 20; m_d = 20; pend = 0; dly = 0;
      prev_owed = 0; prev_d = 20; prev_ej = 1'b0;
      for (int c = 0; c < 900; c++) begin
         @(negedge clk);
         chk("rnd_owed", {27'd0, owed[0]}, m_owed);
         chk("rnd_nickels", {24'd0, ncnt[0]}, m_n);
         chk("rnd_dimes", {24'd0, dcnt[0]}, m_d);
         chk("rnd_no_fault", {31'd0, fault[0]}, 32'd0);
         e_n = ej_n[0];
         e_d = ej_d[0];
         chk("rnd_single_eject", {31'd0, e_n & e_d}, 32'd0);
         chk("rnd_no_back_to_back", {31'd0, (e_n | e_d) & prev_ej}, 32'd0);
         if (e_n | e_d) begin
            chk("rnd_coin_choice", {31'd0, e_d}, {31'd0, (prev_owed >= 2 && prev_d > 0)});
         end

         quiet = (c >= 600);
         rn = !quiet && ($urandom_range(0, 29) == 0);
         rd = !quiet && ($urandom_range(0, 29) == 0);
         r2 = !quiet && ($urandom_range(0, 29) == 0);
         ln = !quiet && ($urandom_range(0, 5) == 0);
         ld = !quiet && ($urandom_range(0, 5) == 0);
         ack = 1'b0; paid = 0;
         if (e_n | e_d) begin
            pend = e_d ? 2 : 1;
            dly  = $urandom_range(1, 6);
         end else if (pend != 0) begin
            dly--;
            if (dly == 0) begin
               ack = 1'b1; paid = pend; pend = 0;
            end
         end else if (!quiet) begin
            ack = ($urandom_range(0, 15) == 0);   // stray confirmation, must be ignored
         end

         prev_owed = m_owed; prev_d = m_d; prev_ej = e_n | e_d;
         tmp = m_owed + int'(rn) + 2 * int'(rd) + 4 * int'(r2) - paid;
         m_owed = (tmp < 0) ? 0 : ((tmp > 31) ? 31 : tmp);
         tmp = m_n + int'(ln) - int'(e_n);
         m_n = (tmp > 255) ? 255 : tmp;
         tmp = m_d + int'(ld) - int'(e_d);
         m_d = (tmp > 255) ? 255 : tmp;
      end
      clear_inputs();
      chk("rnd_drained_owed", {27'd0, owed[0]}, 32'd0);
      chk("rnd_drained_busy", {31'd0, busy[0]}, 32'd0);
   endtask

   typedef struct {
      logic       rn, rd, r2, ack;
      logic       exp_ejn, exp_ejd, exp_busy, exp_fault;
      logic [4:0] exp_owed;
      logic [7:0] exp_n, exp_d;
   } row_t;

   row_t tbl[12];

   function automatic row_t mk(input logic rn_i, rd_i, r2_i, ack_i, ejn_i, ejd_i,
                               busy_i, fault_i, input int owed_i, n_i, d_i);
      row_t r;
      r.rn = rn_i; r.rd = rd_i; r.r2 = r2_i; r.ack = ack_i;
      r.exp_ejn = ejn_i; r.exp_ejd = ejd_i; r.exp_busy = busy_i; r.exp_fault = fault_i;
      r.exp_owed = 5'(owed_i); r.exp_n = 8'(n_i); r.exp_d = 8'(d_i);
      return r;
   endfunction

   initial begin
      int nn, nd, peak, lat, cnt;
      logic [7:0] seq;
      bit seen;

      // ReturnTwoDimes, CoinAck three cycles after each eject; values after each edge.
      //              rn rd r2 ak  ejn ejd bsy flt owed  n   d
      tbl[0]  = mk(0, 0, 0, 1,   0,  0,  0,  0,  0, 20, 20);  // stray ack in IDLE
      tbl[1]  = mk(0, 0, 1, 0,   0,  0,  0,  0,  4, 20, 20);
      tbl[2]  = mk(0, 0, 0, 0,   0,  0,  1,  0,  4, 20, 20);
      tbl[3]  = mk(0, 0, 0, 0,   0,  1,  1,  0,  4, 20, 20);
      tbl[4]  = mk(0, 0, 0, 0,   0,  0,  1,  0,  4, 20, 19);
      tbl[5]  = mk(0, 0, 0, 0,   0,  0,  1,  0,  4, 20, 19);
      tbl[6]  = mk(0, 0, 0, 1,   0,  0,  1,  0,  2, 20, 19);
      tbl[7]  = mk(0, 0, 0, 0,   0,  1,  1,  0,  2, 20, 19);
      tbl[8]  = mk(0, 0, 0, 0,   0,  0,  1,  0,  2, 20, 18);
      tbl[9]  = mk(0, 0, 0, 0,   0,  0,  1,  0,  2, 20, 18);
      tbl[10] = mk(0, 0, 0, 1,   0,  0,  0,  0,  0, 20, 18);
      tbl[11] = mk(0, 0, 0, 0,   0,  0,  0,  0,  0, 20, 18);

      // Reset values while reset is held.
      do_reset();
      reset = 1'b1;
      #1;
      chk("rst_owed", {27'd0, owed[0]}, 32'd0);
      chk("rst_busy", {31'd0, busy[0]}, 32'd0);
      chk("rst_fault", {31'd0, fault[0]}, 32'd0);
      chk("rst_fcode", {30'd0, fcode[0]}, 32'd0);
      chk("rst_nickels_def", {24'd0, ncnt[0]}, 32'd20);
      chk("rst_dimes_def", {24'd0, dcnt[0]}, 32'd20);
      chk("rst_dimes_nodime", {24'd0, dcnt[1]}, 32'd0);
      chk("rst_nickels_short", {24'd0, ncnt[2]}, 32'd0);
      chk("rst_dimes_short", {24'd0, dcnt[2]}, 32'd1);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_idle", {31'd0, busy[0]}, 32'd0);

      // Table-driven two-dime payout.
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         rn = tbl[i].rn; rd = tbl[i].rd; r2 = tbl[i].r2; ack = tbl[i].ack;
         @(posedge clk);
         #1;
         chk($sformatf("tbl%0d_ejn", i), {31'd0, ej_n[0]}, {31'd0, tbl[i].exp_ejn});
         chk($sformatf("tbl%0d_ejd", i), {31'd0, ej_d[0]}, {31'd0, tbl[i].exp_ejd});
         chk($sformatf("tbl%0d_busy", i), {31'd0, busy[0]}, {31'd0, tbl[i].exp_busy});
         chk($sformatf("tbl%0d_fault", i), {31'd0, fault[0]}, {31'd0, tbl[i].exp_fault});
         chk($sformatf("tbl%0d_owed", i), {27'd0, owed[0]}, {27'd0, tbl[i].exp_owed});
         chk($sformatf("tbl%0d_nickels", i), {24'd0, ncnt[0]}, {24'd0, tbl[i].exp_n});
         chk($sformatf("tbl%0d_dimes", i), {24'd0, dcnt[0]}, {24'd0, tbl[i].exp_d});
      end
      @(negedge clk);
      clear_inputs();

      // No dimes in stock: a dime request is paid as two nickels.
      do_reset();
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      payout(1, 1'b0, nn, nd, seq, peak);
      chk("nodime_nickels_paid", nn, 32'd2);
      chk("nodime_dimes_paid", nd, 32'd0);
      chk("nodime_count", {24'd0, ncnt[1]}, 32'd18);
      chk("nodime_owed", {27'd0, owed[1]}, 32'd0);

      // Shortage: one dime paid, then FAULT 01; loading nickels and clearing resumes.
      do_reset();
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      payout(2, 1'b0, nn, nd, seq, peak);
      chk("short_dimes_paid", nd, 32'd1);
      chk("short_fault", {31'd0, fault[2]}, 32'd1);
      chk("short_fcode", {30'd0, fcode[2]}, 32'd1);
      chk("short_owed", {27'd0, owed[2]}, 32'd2);
      ln = 1'b1;
      repeat (2) @(negedge clk);
      ln = 1'b0;
      chk("short_loaded", {24'd0, ncnt[2]}, 32'd2);
      chk("short_still_fault", {31'd0, fault[2]}, 32'd1);
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      chk("short_cleared_fcode", {30'd0, fcode[2]}, 32'd0);
      payout(2, 1'b0, nn, nd, seq, peak);
      chk("short_nickels_paid", nn, 32'd2);
      chk("short_owed_done", {27'd0, owed[2]}, 32'd0);
      chk("short_no_fault", {31'd0, fault[2]}, 32'd0);
      chk("short_nickels_left", {24'd0, ncnt[2]}, 32'd0);

      // Jam: no CoinAck ever; also measures request-to-eject latency.
      do_reset();
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      seen = 1'b0; lat = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         lat++;
         if (ej_n[0]) seen = 1'b1;
      end
      chk("jam_eject_seen", {31'd0, seen}, 32'd1);
      chk("req_to_eject_latency", lat, 32'd2);
      cnt = 0; seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (fault[0]) seen = 1'b1;
         else cnt++;
      end
      chk("jam_wait_cycles", cnt, 32'd15);
      chk("jam_fcode", {30'd0, fcode[0]}, 32'd2);
      chk("jam_owed", {27'd0, owed[0]}, 32'd1);
      chk("jam_nickels", {24'd0, ncnt[0]}, 32'd19);
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      chk("jam_cleared", {31'd0, fault[0]}, 32'd0);
      chk("jam_cleared_fcode", {30'd0, fcode[0]}, 32'd0);
      chk("jam_owed_kept", {27'd0, owed[0]}, 32'd1);

      // Mixed requests: 5 units, plus a dime request during the first wait.
      do_reset();
      pulse(1'b1, 1'b0, 1'b1, 1'b0);
      payout(0, 1'b1, nn, nd, seq, peak);
      chk("mix_peak_owed", peak, 32'd7);
      chk("mix_total_cents", 5 * nn + 10 * nd, 32'd35);
      chk("mix_coin_order", {28'd0, seq[3:0]}, 32'b1110);
      chk("mix_owed_done", {27'd0, owed[0]}, 32'd0);

      // Owed saturates at 31.
      do_reset();
      @(negedge clk);
      rn = 1'b1; rd = 1'b1; r2 = 1'b1;
      repeat (5) @(negedge clk);
      clear_inputs();
      chk("owed_saturate", {27'd0, owed[0]}, 32'd31);

      // Inventory saturates at 255.
      do_reset();
      @(negedge clk);
      ln = 1'b1; ld = 1'b1;
      repeat (240) @(negedge clk);
      clear_inputs();
      chk("nickel_saturate", {24'd0, ncnt[0]}, 32'd255);
      chk("dime_saturate", {24'd0, dcnt[0]}, 32'd255);

      // Reset in the middle of WAIT_ACK takes effect within the cycle.
      do_reset();
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (ej_d[0]) seen = 1'b1;
      end
      chk("midrst_eject_seen", {31'd0, seen}, 32'd1);
      @(negedge clk);
      chk("midrst_waiting", {31'd0, busy[0]}, 32'd1);
      chk("midrst_dimes_before", {24'd0, dcnt[0]}, 32'd19);
      #2 reset = 1'b1;
      #1;
      chk("midrst_owed", {27'd0, owed[0]}, 32'd0);
      chk("midrst_busy", {31'd0, busy[0]}, 32'd0);
      chk("midrst_eject", {30'd0, ej_n[0], ej_d[0]}, 32'd0);
      chk("midrst_fault", {29'd0, fault[0], fcode[0]}, 32'd0);
      chk("midrst_nickels", {24'd0, ncnt[0]}, 32'd20);
      chk("midrst_dimes", {24'd0, dcnt[0]}, 32'd20);
      @(negedge clk);
      reset = 1'b0;

      // Randomised run against the reference model.
      do_reset();
      random_run();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
